// File: rtl/mux_arbiter_pkg.sv
// Shared encodings for the two-channel arbitrating multiplexer.
package mux_arbiter_pkg;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Channel that was not served; receives priority after an acceptance.
    function automatic ch_e other_ch(input ch_e ch);
        return (ch == CH0) ? CH1 : CH0;
    endfunction

endpackage

// File: rtl/mux_arbiter_rr_grant2.sv
// Two-requester grant: sole requester wins, ties go to the priority holder.
module rr_grant2
    import mux_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  ch_e  pri,
    output logic gnt_valid_c,
    output ch_e  gnt_idx_c
);

    // Combinational grant decision
    always_comb begin
        gnt_valid_c = valid0 | valid1;
        gnt_idx_c   = CH0;
        if (valid0 && valid1) begin
            gnt_idx_c = pri;
        end else if (valid1) begin
            gnt_idx_c = CH1;
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Two-channel arbitrating multiplexer with a single registered output slot.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned INIT_PRI = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready
);

    localparam ch_e RST_PRI = ch_e'(1'(INIT_PRI));

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    ch_e              sel_q,   sel_d;
    ch_e              pri_q,   pri_d;

    logic gnt_valid_c;
    ch_e  gnt_idx_c;
    logic can_load_c;
    logic accept_c;

    rr_grant2 u_grant (
        .valid0      (in0_valid),
        .valid1      (in1_valid),
        .pri         (pri_q),
        .gnt_valid_c (gnt_valid_c),
        .gnt_idx_c   (gnt_idx_c)
    );

    // Slot can take a word when empty or being drained this cycle
    assign can_load_c = (state_q == EMPTY) | out_ready;
    assign accept_c   = ~rst & can_load_c & gnt_valid_c;

    assign in0_ready = accept_c & (gnt_idx_c == CH0);
    assign in1_ready = accept_c & (gnt_idx_c == CH1);

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

    // Next-state, payload and priority update
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        pri_d   = pri_q;
        if (accept_c) begin
            state_d = FULL;
            data_d  = (gnt_idx_c == CH1) ? in1_data : in0_data;
            sel_d   = gnt_idx_c;
            pri_d   = other_ch(gnt_idx_c);
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    // State, output slot and priority registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= CH0;
            pri_q   <= RST_PRI;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            pri_q   <= pri_d;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed steps plus randomized traffic.
module tb_mux_arbiter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in0_valid, in1_valid, out_ready;
    logic [W-1:0] in0_data, in1_data;
    logic         in0_ready, in1_ready, out_valid, out_sel;
    logic [W-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    // Reference: output slot contents, priority, and queue of accepted words
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_sel;
    logic         m_pri;
    logic [W:0]   sb[$];

    mux_arbiter #(.WIDTH(W), .INIT_PRI(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check, advance model at posedge
    task automatic step(input logic r, input logic v0, input logic [W-1:0] d0,
                        input logic v1, input logic [W-1:0] d1, input logic ordy);
        logic         can_load, g, gi, acc, cons;
        logic [W:0]   head;
        @(negedge clk);
        rst = r; in0_valid = v0; in0_data = d0;
        in1_valid = v1; in1_data = d1; out_ready = ordy;
        #1;
        can_load = !m_valid || ordy;
        g  = v0 || v1;
        gi = (v0 && v1) ? m_pri : v1;
        acc  = !r && can_load && g;
        cons = !r && m_valid && ordy;
        chk("in0_ready", 32'(in0_ready), 32'(acc && !gi));
        chk("in1_ready", 32'(in1_ready), 32'(acc && gi));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_sel",   32'(out_sel),   32'(m_sel));
        if (cons) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                head = sb.pop_front();
                chk("sb_order", 32'({out_sel, out_data}), 32'(head));
            end
        end
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_data = '0; m_sel = 1'b0; m_pri = 1'b0;
            sb.delete();
        end else if (acc) begin
            m_valid = 1'b1;
            m_sel   = gi;
            m_data  = gi ? d1 : d0;
            m_pri   = !gi;
            sb.push_back({gi, m_data});
        end else if (cons) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b1, 8'haa, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        in0_data = '0; in1_data = '0;
        m_valid = 1'b0; m_data = '0; m_sel = 1'b0; m_pri = 1'b0;

        // Reset state
        do_reset();
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);

        // Single word from channel 0, latency one cycle
        step(1'b0, 1'b1, 8'd1, 1'b0, 8'd0, 1'b1);
        #1;
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_data",  32'(out_data),  32'd1);
        chk("one_sel",   32'(out_sel),   32'd0);

        // Both valid back to back: alternating 0,1,0,1 at one word per cycle
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 8'd0, 1'b1, 8'd1, 1'b1);
            #1;
            chk("alt_sel",  32'(out_sel),  32'(k % 2));
            chk("alt_data", 32'(out_data), 32'(k % 2));
            chk("alt_valid", 32'(out_valid), 32'd1);
        end

        // Backpressure: hold for 3 cycles, then drain and reload in one edge
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h10, 1'b1, 8'h21, 1'b0);
        step(1'b0, 1'b1, 8'h10, 1'b1, 8'h21, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Drain with no grant, priority must stay put afterwards
        step(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #1;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_data",  32'(out_data),  32'h33);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h44, 1'b1, 8'h45, 1'b1);
        #1;
        chk("pri_kept", 32'(out_sel), 32'd1);

        // Reset while FULL and stalled: word discarded, priority back to 0
        step(1'b0, 1'b1, 8'h66, 1'b1, 8'h67, 1'b1);
        step(1'b0, 1'b1, 8'h66, 1'b1, 8'h67, 1'b0);
        step(1'b1, 1'b1, 8'h66, 1'b1, 8'h67, 1'b0);
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sel",   32'(out_sel),   32'd0);
        step(1'b0, 1'b1, 8'h70, 1'b1, 8'h71, 1'b1);
        #1;
        chk("mid_rst_pri", 32'(out_sel), 32'd0);

        // Sweep of {in0_valid, in1_valid, out_ready}
        for (int rep = 0; rep < 4; rep++) begin
            for (int c = 0; c < 8; c++) begin
                logic [2:0] cv;
                cv = 3'(c);
                step(1'b0, cv[2], W'($urandom), cv[1], W'($urandom), cv[0]);
            end
        end

        // Randomized traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom), W'($urandom),
                 1'($urandom), W'($urandom), 1'($urandom));
        end

        // Flush remaining word through the scoreboard
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
